wfg_mem_reader: RTL and testbench

Streaming read engine that sits directly upstream of merge_memory. It drives that block's chip-select and 10-bit address, and captures its 32-bit read data. It walks a configurable address window of the 1024-word merged waveform memory and repeats the window continuously. Samples leave on an AXI-Stream-style valid/ready master port into the waveform core, and a small internal FIFO absorbs the 1-cycle SRAM read latency and downstream backpressure.

---
 rtl/wfg_mem_reader_pkg.sv | 16 +
 rtl/wfg_mem_reader_fifo.sv | 55 +++++
 rtl/wfg_mem_reader.sv | 173 +++++++++++++++++
 tb/tb_wfg_mem_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wfg_mem_reader_pkg.sv
// Shared constants, FSM state codes and FIFO entry layout for the merged-memory stream reader.
package wfg_mem_reader_pkg;

    localparam int MEM_ADDR_WIDTH = 10;
    localparam int MEM_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic                      tlast;
        logic [MEM_DATA_WIDTH-1:0] tdata;
    } fifo_entry_t;

endpackage

// File: rtl/wfg_mem_reader_fifo.sv
// Small synchronous FIFO with push/pop/flush and occupancy count; entry type is a parameter.
module wfg_mem_reader_fifo
    import wfg_mem_reader_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fifo_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  T                           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output T                           o_head,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_full;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_occ   = r_cnt;
    assign o_head  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    // Credit accounting upstream must make this impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_flush && w_full));

endmodule

// File: rtl/wfg_mem_reader.sv
// Streaming reader for merge_memory: loops an address window onto a valid/ready master port.
// Optional WFG_MEM_READER_LOOP_CNT_EN adds a pass counter (loop_cnt_i) and a done_o pulse.
module wfg_mem_reader #(
    parameter int MEM_ADDR_WIDTH = wfg_mem_reader_pkg::MEM_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = wfg_mem_reader_pkg::MEM_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [MEM_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [MEM_ADDR_WIDTH-1:0] end_addr_i,
    output logic                      csb_o,
    output logic [MEM_ADDR_WIDTH-1:0] addr_o,
    input  logic [MEM_DATA_WIDTH-1:0] dout_i,
    output logic [MEM_DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                      m_axis_tvalid_o,
    input  logic                      m_axis_tready_i,
    output logic                      m_axis_tlast_o,
    output logic                      busy_o
`ifdef WFG_MEM_READER_LOOP_CNT_EN
   ,input  logic [15:0]               loop_cnt_i,
    output logic                      done_o
`endif
);

    import wfg_mem_reader_pkg::*;

    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = OW + 1;

    typedef struct packed {
        logic                      tlast;
        logic [MEM_DATA_WIDTH-1:0] tdata;
    } entry_t;

    logic [1:0]                r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_start;
    logic [MEM_ADDR_WIDTH-1:0] r_end;
    logic [MEM_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [MEM_ADDR_WIDTH-1:0] r_last_addr;
    logic                      r_outstanding;
    logic                      r_out_tlast;

    logic          w_run;
    logic          w_tvalid;
    logic          w_pop;
    logic          w_push;
    logic          w_flush;
    logic          w_empty;
    logic [OW-1:0] w_occ;
    logic          w_credit_ok;
    logic          w_issue;
    logic          w_issue_last;
    logic          w_start;
    logic          w_stop;
    logic          w_done_now;
    logic          w_block_start;
    entry_t        w_head;
    entry_t        w_push_data;

    assign w_run    = (r_state == ST_RUN);
    assign w_tvalid = w_run && !w_empty;
    assign w_pop    = w_tvalid && m_axis_tready_i;
    assign w_push   = w_run && r_outstanding;
    assign w_flush  = (r_state == ST_DRAIN);

    // A slot freed by this cycle's pop may be reused by this cycle's read.
    assign w_credit_ok  = (CW'(w_occ) + CW'(r_outstanding)) < (CW'(FIFO_DEPTH) + CW'(w_pop));
    assign w_issue      = w_run && en_i && w_credit_ok && !w_stop;
    assign w_issue_last = w_issue && (r_rd_ptr == r_end);
    assign w_start      = (r_state == ST_IDLE) && en_i && !w_block_start;

    assign w_push_data = '{tlast: r_out_tlast, tdata: dout_i};

    wfg_mem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_occ       (w_occ)
    );

    assign csb_o           = !w_issue;
    assign addr_o          = w_issue ? r_rd_ptr : r_last_addr;
    assign m_axis_tvalid_o = w_tvalid;
    assign m_axis_tdata_o  = w_tvalid ? w_head.tdata : '0;
    assign m_axis_tlast_o  = w_tvalid && w_head.tlast;
    assign busy_o          = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_start       <= '0;
            r_end         <= '0;
            r_rd_ptr      <= '0;
            r_last_addr   <= '0;
            r_outstanding <= 1'b0;
            r_out_tlast   <= 1'b0;
        end else begin
            r_outstanding <= w_issue;
            if (w_issue) begin
                r_out_tlast <= w_issue_last;
                r_last_addr <= r_rd_ptr;
                r_rd_ptr    <= w_issue_last ? r_start : r_rd_ptr + MEM_ADDR_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_start  <= start_addr_i;
                        r_end    <= end_addr_i;
                        r_rd_ptr <= start_addr_i;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_done_now)  r_state <= ST_IDLE;
                    else if (!en_i)  r_state <= ST_DRAIN;
                end
                ST_DRAIN: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef WFG_MEM_READER_LOOP_CNT_EN
    logic [15:0] r_loop_tgt;
    logic [15:0] r_pass_cnt;
    logic        r_stop;
    logic        r_done;
    logic        r_wait_low;

    assign w_stop        = r_stop;
    assign w_done_now    = w_run && r_stop && !r_outstanding && w_empty;
    assign w_block_start = r_wait_low;
    assign done_o        = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_loop_tgt <= '0;
            r_pass_cnt <= '0;
            r_stop     <= 1'b0;
            r_done     <= 1'b0;
            r_wait_low <= 1'b0;
        end else begin
            r_done <= w_done_now;
            if (w_done_now)  r_wait_low <= 1'b1;
            else if (!en_i)  r_wait_low <= 1'b0;
            if (w_start) begin
                r_loop_tgt <= loop_cnt_i;
                r_pass_cnt <= '0;
                r_stop     <= 1'b0;
            end else if (w_issue_last) begin
                r_pass_cnt <= r_pass_cnt + 16'd1;
                // Zero target means loop forever.
                if (r_loop_tgt != '0 && (r_pass_cnt + 16'd1) == r_loop_tgt) r_stop <= 1'b1;
            end
        end
    end
`else
    assign w_stop        = 1'b0;
    assign w_done_now    = 1'b0;
    assign w_block_start = 1'b0;
`endif

endmodule

// File: tb/tb_wfg_mem_reader.sv
// Randomized bench: SRAM model plus window/credit scoreboard for wfg_mem_reader.
module tb_wfg_mem_reader;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic [AW-1:0] start_addr_i = '0;
    logic [AW-1:0] end_addr_i = '0;
    logic          csb_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] dout_i = '0;
    logic [DW-1:0] m_axis_tdata_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tready_i = 1'b0;
    logic          m_axis_tlast_o;
    logic          busy_o;
`ifdef WFG_MEM_READER_LOOP_CNT_EN
    logic [15:0]   loop_cnt_i = '0;
    logic          done_o;
`endif

    logic [DW-1:0] mem [1024];
    int n_chk = 0;
    int n_pass = 0;

    wfg_mem_reader #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_i            (en_i),
        .start_addr_i    (start_addr_i),
        .end_addr_i      (end_addr_i),
        .csb_o           (csb_o),
        .addr_o          (addr_o),
        .dout_i          (dout_i),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .busy_o          (busy_o)
`ifdef WFG_MEM_READER_LOOP_CNT_EN
       ,.loop_cnt_i      (loop_cnt_i),
        .done_o          (done_o)
`endif
    );

    always #5 clk = ~clk;

    // SRAM: data appears the cycle after a selected read.
    always @(posedge clk) if (!csb_o) dout_i <= mem[addr_o];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [AW-1:0] s,
                                          input logic [AW-1:0] e);
        return (a == e) ? s : a + 10'd1;
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_csb"},   64'(csb_o), 64'd1);
        chk({tag, "_addr"},  64'(addr_o), 64'd0);
        chk({tag, "_tdata"}, 64'(m_axis_tdata_o), 64'd0);
        chk({tag, "_tvld"},  64'(m_axis_tvalid_o), 64'd0);
        chk({tag, "_tlast"}, 64'(m_axis_tlast_o), 64'd0);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
    endtask

    // Enables a window and scoreboards nbeats transfers; leaves en_i high.
    task automatic stream(input logic [AW-1:0] s, input logic [AW-1:0] e, input int nbeats,
                          input int rdy_pct, input bit lat);
        logic [AW-1:0] ai, ab;
        int iss, xf, cyc;
        bit stl, seen, pop, cr;
        logic [DW-1:0] hd;
        logic hl;
        ai = s; ab = s; iss = 0; xf = 0; cyc = 0;
        stl = 1'b0; seen = 1'b0; hd = '0; hl = 1'b0;
        @(posedge clk); #1;
        start_addr_i = s; end_addr_i = e; en_i = 1'b1; m_axis_tready_i = 1'b0;
        while (xf < nbeats && cyc < nbeats * 20 + 50) begin
            @(posedge clk); #1;
            cyc++;
            m_axis_tready_i = ($urandom_range(99) < rdy_pct);
            start_addr_i = 10'($urandom);
            end_addr_i   = 10'($urandom);
            @(negedge clk);
            if (lat && cyc == 1) chk("lat_csb", 64'(csb_o), 64'd0);
            if (lat && cyc == 2) chk("lat_vld2", 64'(m_axis_tvalid_o), 64'd0);
            if (lat && cyc == 3) chk("lat_vld3", 64'(m_axis_tvalid_o), 64'd1);
            pop = m_axis_tvalid_o && m_axis_tready_i;
            cr  = (iss - xf) < DEPTH + int'(pop);
            chk("issue", 64'(!csb_o), 64'(cr));
            if (!csb_o) begin
                chk("iss_addr", 64'(addr_o), 64'(ai));
                ai = nxt(ai, s, e);
                iss++;
            end
            if (stl) chk("hold", 64'({m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o}),
                         64'({1'b1, hl, hd}));
            if (rdy_pct >= 100 && seen) chk("thru", 64'(m_axis_tvalid_o), 64'd1);
            if (pop) begin
                chk("tdata", 64'(m_axis_tdata_o), 64'(mem[ab]));
                chk("tlast", 64'(m_axis_tlast_o), 64'(ab == e));
                ab = nxt(ab, s, e);
                xf++;
            end
            seen = seen || m_axis_tvalid_o;
            stl  = m_axis_tvalid_o && !m_axis_tready_i;
            hd   = m_axis_tdata_o;
            hl   = m_axis_tlast_o;
        end
        chk("beats", 64'(xf), 64'(nbeats));
    endtask

    task automatic stop_run();
        @(posedge clk); #1;
        en_i = 1'b0; m_axis_tready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drn_vld", 64'(m_axis_tvalid_o), 64'd0);
        chk("drn_busy", 64'(busy_o), 64'd1);
        chk("drn_csb", 64'(csb_o), 64'd1);
        @(negedge clk);
        chk("idle_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        stream(10'h000, 10'h003, 12, 100, 1'b1);
        stop_run();
        stream(10'h3FE, 10'h001, 12, 100, 1'b1);
        stop_run();
        stream(10'h155, 10'h155, 10, 100, 1'b0);
        stop_run();

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        stream(10'h010, 10'h01F, 200, 50, 1'b0);
        stop_run();
        for (int r = 0; r < 3; r++) begin
            stream(10'($urandom), 10'($urandom), 40, 30 + 35 * r, 1'b0);
            stop_run();
        end

        // Disable with the FIFO full, then restart from the configured start.
        stream(10'h040, 10'h047, 5, 100, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
            m_axis_tready_i = 1'b0;
        end
        @(negedge clk);
        chk("full_vld", 64'(m_axis_tvalid_o), 64'd1);
        stop_run();
        stream(10'h040, 10'h047, 6, 100, 1'b1);
        stop_run();

`ifdef WFG_MEM_READER_LOOP_CNT_EN
        begin
            int beats, dones;
            beats = 0; dones = 0;
            @(posedge clk); #1;
            loop_cnt_i = 16'd2; start_addr_i = 10'h000; end_addr_i = 10'h003;
            en_i = 1'b1; m_axis_tready_i = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (m_axis_tvalid_o && m_axis_tready_i) begin
                    chk("lp_tdata", 64'(m_axis_tdata_o), 64'(mem[beats % 4]));
                    beats++;
                end
                if (done_o) begin
                    dones++;
                    chk("lp_busy", 64'(busy_o), 64'd0);
                end
            end
            chk("lp_beats", 64'(beats), 64'd8);
            chk("lp_done", 64'(dones), 64'd1);
            chk("lp_idle", 64'(busy_o), 64'd0);
            @(posedge clk); #1;
            en_i = 1'b0; loop_cnt_i = '0;
            repeat (2) @(posedge clk);
        end
`endif

        // Reset in the middle of a stream.
        stream(10'h020, 10'h02F, 10, 100, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; en_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_rst("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
